fsk_ber_meter: RTL

- Sits downstream of the FSK byte receiver and compares each received byte with the byte currently selected for transmission (TX_DAT) in loopback.
- Accumulates byte, bit-error and errored-byte counts over a fixed window of bytes.
- Runs a watchdog on the receive stream. Results drive the display mux and the LED bar.

---
 rtl/fsk_ber_meter_if.sv | 28 ++
 rtl/fsk_ber_meter.sv | 115 +++++++++++
 2 files changed

// File: rtl/fsk_ber_meter_if.sv
// Bundle of the BER meter's receive-side inputs and measurement results.
// master drives stimulus/loopback data; slave is the meter itself.
interface fsk_ber_meter_if #(
  parameter int CNT_W = 16
);
  logic             ce10ms;
  logic             start;
  logic             en_rx_byte;
  logic [7:0]       RX_DAT;
  logic [7:0]       TX_DAT;
  logic [CNT_W-1:0] BYTE_CNT;
  logic [CNT_W-1:0] ERR_BITS;
  logic [CNT_W-1:0] ERR_BYTES;
  logic [7:0]       LAST_XOR;
  logic             busy;
  logic             done;
  logic             link_ok;

  modport master (
    output ce10ms, start, en_rx_byte, RX_DAT, TX_DAT,
    input  BYTE_CNT, ERR_BITS, ERR_BYTES, LAST_XOR, busy, done, link_ok
  );

  modport slave (
    input  ce10ms, start, en_rx_byte, RX_DAT, TX_DAT,
    output BYTE_CNT, ERR_BITS, ERR_BYTES, LAST_XOR, busy, done, link_ok
  );
endinterface

// File: rtl/fsk_ber_meter.sv
// Loopback bit-error-rate meter: compares each received FSK byte with the
// transmitted byte over a fixed window and watches the link for silence.
module fsk_ber_meter #(
  parameter int WIN_BYTES = 100,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 50
) (
  input  logic              clk,
  input  logic              rst,
  fsk_ber_meter_if.slave    bus
);

  localparam int               WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_BYTES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_PRE   = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic             en_d;
  logic             acc;
  logic             count_en;
  logic [7:0]       x;
  logic [3:0]       pc;
  logic [CNT_W:0]   bits_sum;
  logic [WD_W-1:0]  wd;

  logic [CNT_W-1:0] byte_cnt, err_bits, err_bytes;
  logic [7:0]       last_xor;
  logic             busy_q, done_q, link_ok_q;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  assign acc      = en_d & ~bus.en_rx_byte;
  assign x        = bus.RX_DAT ^ bus.TX_DAT;
  assign pc       = popcount(x);
  assign bits_sum = {1'b0, err_bits} + (CNT_W+1)'(pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // start overrides everything, including a coincident byte event
  always_comb begin
    state_nx = state;
    count_en = 1'b0;
    if (bus.start) begin
      state_nx = RUN;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        RUN: begin
          if (acc) begin
            count_en = 1'b1;
            if (byte_cnt == WIN_LAST) state_nx = DONE;
          end
        end
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_d      <= 1'b0;
      byte_cnt  <= '0;
      err_bits  <= '0;
      err_bytes <= '0;
      last_xor  <= '0;
      wd        <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      link_ok_q <= 1'b0;
    end else begin
      en_d   <= bus.en_rx_byte;
      busy_q <= (state_nx == RUN);
      done_q <= (state_nx == DONE);
      if (bus.start) begin
        byte_cnt  <= '0;
        err_bits  <= '0;
        err_bytes <= '0;
        last_xor  <= '0;
        wd        <= '0;
        link_ok_q <= 1'b0;
      end else if (count_en) begin
        last_xor  <= x;
        byte_cnt  <= byte_cnt + 1'b1;
        err_bits  <= bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
        if (x != 8'h00) err_bytes <= err_bytes + 1'b1;
        wd        <= '0;
        link_ok_q <= 1'b1;
      end else if (state == RUN && bus.ce10ms && wd != WD_MAX) begin
        wd <= wd + 1'b1;
        if (wd == WD_PRE) link_ok_q <= 1'b0;
      end
    end
  end

  assign bus.BYTE_CNT  = byte_cnt;
  assign bus.ERR_BITS  = err_bits;
  assign bus.ERR_BYTES = err_bytes;
  assign bus.LAST_XOR  = last_xor;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.link_ok   = link_ok_q;

endmodule
